// File: rtl/bf_pkg.sv
// Shared opcode constants, FSM state type and instruction-format helper for the Brainfuck core.
package bf_pkg;

    // Opcode field width; an instruction is PC_W + OP_W bits wide.
    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD   = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB   = 3'd1;
    localparam logic [OP_W-1:0] OP_RIGHT = 3'd2;
    localparam logic [OP_W-1:0] OP_LEFT  = 3'd3;
    localparam logic [OP_W-1:0] OP_OUT   = 3'd4;
    localparam logic [OP_W-1:0] OP_IN    = 3'd5;
    localparam logic [OP_W-1:0] OP_JZ    = 3'd6;
    localparam logic [OP_W-1:0] OP_JNZ   = 3'd7;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec,
        StOut,
        StIn,
        StHalt
    } state_e;

endpackage

// File: rtl/bf_exec_unit.sv
// Combinational datapath: next pc, next dp and updated cell value for one decoded instruction.
module bf_exec_unit
    import bf_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DP_W   = 16,
    parameter int unsigned PC_W   = 13
) (
    input  logic [OP_W-1:0]   i_op,
    input  logic [PC_W-1:0]   i_arg,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [DP_W-1:0]   i_dp,
    input  logic [DATA_W-1:0] i_cell,
    output logic [PC_W-1:0]   o_next_pc,
    output logic [DP_W-1:0]   o_next_dp,
    output logic [DATA_W-1:0] o_new_cell
);

    // Arithmetic is done at the wider of the two operand widths, then truncated.
    localparam int unsigned CW = (DATA_W > PC_W) ? DATA_W : PC_W;
    localparam int unsigned DW = (DP_W > PC_W) ? DP_W : PC_W;

    logic [CW-1:0]   w_cell_add;
    logic [CW-1:0]   w_cell_sub;
    logic [DW-1:0]   w_dp_add;
    logic [DW-1:0]   w_dp_sub;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_arg_inc;

    assign w_cell_add = CW'(i_cell) + CW'(i_arg);
    assign w_cell_sub = CW'(i_cell) - CW'(i_arg);
    assign w_dp_add   = DW'(i_dp) + DW'(i_arg);
    assign w_dp_sub   = DW'(i_dp) - DW'(i_arg);
    assign w_pc_inc   = i_pc + PC_W'(1);
    assign w_arg_inc  = i_arg + PC_W'(1);

    always_comb begin
        o_next_pc  = w_pc_inc;
        o_next_dp  = i_dp;
        o_new_cell = i_cell;
        case (i_op)
            OP_ADD:   o_new_cell = DATA_W'(w_cell_add);
            OP_SUB:   o_new_cell = DATA_W'(w_cell_sub);
            OP_RIGHT: o_next_dp  = DP_W'(w_dp_add);
            OP_LEFT:  o_next_dp  = DP_W'(w_dp_sub);
            OP_JZ: begin
                if (i_cell == '0) o_next_pc = w_arg_inc;
            end
            OP_JNZ: begin
                if (i_cell != '0) o_next_pc = w_arg_inc;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bf_core.sv
// Brainfuck core: FETCH/EXEC FSM over synchronous instruction and data RAMs with stream I/O.
// Optional cycle counter enabled by defining BF_CORE_CYCLE_COUNT_EN.
module bf_core
    import bf_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DP_W   = 16,
    parameter int unsigned PC_W   = 13,
    parameter int unsigned CYC_W  = 40
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 run,
    output logic [PC_W-1:0]      imem_addr,
    input  logic [PC_W+OP_W-1:0] imem_rdata,
    output logic [DP_W-1:0]      dmem_addr,
    input  logic [DATA_W-1:0]    dmem_rdata,
    output logic                 dmem_we,
    output logic [DATA_W-1:0]    dmem_wdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 halted,
    output logic [CYC_W-1:0]     cycles
);

    state_e              r_state;
    state_e              w_state_d;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     w_pc_d;
    logic [DP_W-1:0]     r_dp;
    logic [DP_W-1:0]     w_dp_d;
    logic [DATA_W-1:0]   r_out_data;
    logic [DATA_W-1:0]   w_out_data_d;

    logic [OP_W-1:0]     w_op;
    logic [PC_W-1:0]     w_arg;
    logic                w_is_halt;
    logic [PC_W-1:0]     w_next_pc;
    logic [DP_W-1:0]     w_next_dp;
    logic [DATA_W-1:0]   w_new_cell;

    assign w_op      = imem_rdata[PC_W+OP_W-1:PC_W];
    assign w_arg     = imem_rdata[PC_W-1:0];
    assign w_is_halt = (imem_rdata == '0);

    bf_exec_unit #(
        .DATA_W (DATA_W),
        .DP_W   (DP_W),
        .PC_W   (PC_W)
    ) u_exec (
        .i_op       (w_op),
        .i_arg      (w_arg),
        .i_pc       (r_pc),
        .i_dp       (r_dp),
        .i_cell     (dmem_rdata),
        .o_next_pc  (w_next_pc),
        .o_next_dp  (w_next_dp),
        .o_new_cell (w_new_cell)
    );

    always_comb begin
        w_state_d    = r_state;
        w_pc_d       = r_pc;
        w_dp_d       = r_dp;
        w_out_data_d = r_out_data;
        dmem_we      = 1'b0;
        dmem_wdata   = '0;
        unique case (r_state)
            StIdle: begin
                if (run) w_state_d = StFetch;
            end
            StFetch: w_state_d = StExec;
            StExec: begin
                w_pc_d = w_next_pc;
                if (w_is_halt) begin
                    // The all-zero word decodes as OP_ADD but must not write.
                    w_state_d = StHalt;
                end else begin
                    w_dp_d    = w_next_dp;
                    w_state_d = StFetch;
                    case (w_op)
                        OP_ADD, OP_SUB: begin
                            dmem_we    = 1'b1;
                            dmem_wdata = w_new_cell;
                        end
                        OP_OUT: begin
                            w_out_data_d = dmem_rdata;
                            w_state_d    = StOut;
                        end
                        OP_IN:   w_state_d = StIn;
                        default: ;
                    endcase
                end
            end
            StOut: begin
                if (out_ready) w_state_d = StFetch;
            end
            StIn: begin
                if (in_valid) begin
                    dmem_we    = 1'b1;
                    dmem_wdata = in_data;
                    w_state_d  = StFetch;
                end
            end
            StHalt: ;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_pc       <= '0;
            r_dp       <= '0;
            r_out_data <= '0;
        end else begin
            r_state    <= w_state_d;
            r_pc       <= w_pc_d;
            r_dp       <= w_dp_d;
            r_out_data <= w_out_data_d;
        end
    end

    assign imem_addr = r_pc;
    assign dmem_addr = r_dp;
    assign out_valid = (r_state == StOut);
    assign out_data  = r_out_data;
    assign in_ready  = (r_state == StIn);
    assign halted    = (r_state == StHalt);

`ifdef BF_CORE_CYCLE_COUNT_EN
    logic [CYC_W-1:0] r_cycles;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cycles <= '0;
        end else if (r_state != StIdle && r_state != StHalt) begin
            r_cycles <= r_cycles + CYC_W'(1);
        end
    end

    assign cycles = r_cycles;
`else
    assign cycles = '0;
`endif

endmodule

// File: tb/tb_bf_core.sv
// Self-checking bench for bf_core: RAM models, an interpreter-level reference model,
// directed programs and randomized programs with random stream handshakes.
module tb_bf_core;

    localparam int PH_IDLE = 0;
    localparam int PH_FETCH = 1;
    localparam int PH_EXEC = 2;
    localparam int PH_OUT = 3;
    localparam int PH_IN = 4;
    localparam int PH_HALT = 5;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic [12:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] dmem_addr;
    logic [7:0]  dmem_rdata;
    logic        dmem_we;
    logic [7:0]  dmem_wdata;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        halted;
    logic [39:0] cycles;

    always #5 clock = ~clock;

    bf_core #(
        .DATA_W (8),
        .DP_W   (16),
        .PC_W   (13),
        .CYC_W  (40)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .run        (run),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .dmem_addr  (dmem_addr),
        .dmem_rdata (dmem_rdata),
        .dmem_we    (dmem_we),
        .dmem_wdata (dmem_wdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .halted     (halted),
        .cycles     (cycles)
    );

    // Synchronous RAMs; data RAM is (re)loaded from init_mem only on request.
    logic [15:0] imem     [0:8191];
    logic [7:0]  dmem     [0:65535];
    logic [7:0]  init_mem [0:65535];
    logic [15:0] imem_q;
    logic [7:0]  dmem_q;
    bit          load_req = 1'b0;

    assign imem_rdata = imem_q;
    assign dmem_rdata = dmem_q;

    always @(posedge clock) begin
        imem_q <= imem[imem_addr];
        if (load_req) begin
            for (int i = 0; i < 65536; i++) dmem[i] <= init_mem[i];
        end else if (dmem_we) begin
            dmem[dmem_addr] <= dmem_wdata;
        end
        dmem_q <= dmem[dmem_addr];
    end

    // Reference model: an interpreter stepping one phase per clock.
    int          m_phase;
    logic [12:0] m_pc;
    logic [15:0] m_dp;
    logic [7:0]  m_out;
    logic [39:0] m_cycles;
    int          m_pc2_cnt;
    logic [7:0]  m_mem [0:65535];
    int          e_ins, e_op, e_a, e_cell;

    always_comb begin
        e_ins  = int'(imem[m_pc]);
        e_op   = e_ins >> 13;
        e_a    = e_ins & 8191;
        e_cell = int'(m_mem[m_dp]);
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_phase   <= PH_IDLE;
            m_pc      <= '0;
            m_dp      <= '0;
            m_out     <= '0;
            m_cycles  <= '0;
            m_pc2_cnt <= 0;
            if (load_req) begin
                for (int i = 0; i < 65536; i++) m_mem[i] <= init_mem[i];
            end
        end else begin
`ifdef BF_CORE_CYCLE_COUNT_EN
            if (m_phase != PH_IDLE && m_phase != PH_HALT) m_cycles <= m_cycles + 40'd1;
`endif
            case (m_phase)
                PH_IDLE:  if (run) m_phase <= PH_FETCH;
                PH_FETCH: m_phase <= PH_EXEC;
                PH_EXEC: begin
                    m_pc    <= m_pc + 13'd1;
                    m_phase <= PH_FETCH;
                    if (e_ins == 0) begin
                        m_phase <= PH_HALT;
                    end else begin
                        if (m_pc == 13'd2 && e_op == 1) m_pc2_cnt <= m_pc2_cnt + 1;
                        case (e_op)
                            0: m_mem[m_dp] <= 8'((e_cell + e_a) & 255);
                            1: m_mem[m_dp] <= 8'((e_cell - e_a) & 255);
                            2: m_dp <= 16'((int'(m_dp) + e_a) & 65535);
                            3: m_dp <= 16'((int'(m_dp) - e_a) & 65535);
                            4: begin
                                m_out   <= 8'(e_cell);
                                m_phase <= PH_OUT;
                            end
                            5: m_phase <= PH_IN;
                            6: m_pc <= 13'((((e_cell == 0) ? e_a : int'(m_pc)) + 1) % 8192);
                            default: m_pc <= 13'((((e_cell != 0) ? e_a : int'(m_pc)) + 1) % 8192);
                        endcase
                    end
                end
                PH_OUT: if (out_ready) m_phase <= PH_FETCH;
                PH_IN: begin
                    if (in_valid) begin
                        m_mem[m_dp] <= in_data;
                        m_phase     <= PH_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] q_dut[$];
    logic [7:0] m_outq[$];
    int         wr_cnt;
    logic [15:0] last_wa;
    logic [7:0]  last_wd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle_check();
        logic       exp_we;
        logic [7:0] exp_wd;
        exp_we = 1'b0;
        exp_wd = 8'h00;
        if (m_phase == PH_EXEC && e_ins != 0 && e_op <= 1) begin
            exp_we = 1'b1;
            exp_wd = (e_op == 0) ? 8'((e_cell + e_a) & 255) : 8'((e_cell - e_a) & 255);
        end else if (m_phase == PH_IN && in_valid) begin
            exp_we = 1'b1;
            exp_wd = in_data;
        end
        check("dmem_we", dmem_we, exp_we);
        check("dmem_wdata", dmem_wdata, exp_wd);
        check("dmem_addr", dmem_addr, m_dp);
        if (m_phase != PH_HALT) check("imem_addr", imem_addr, m_pc);
        check("out_valid", out_valid, m_phase == PH_OUT);
        check("out_data", out_data, m_out);
        check("in_ready", in_ready, m_phase == PH_IN);
        check("halted", halted, m_phase == PH_HALT);
        check("cycles", cycles, m_cycles);
        if (out_valid && out_ready) q_dut.push_back(out_data);
        if (m_phase == PH_OUT && out_ready) m_outq.push_back(m_out);
        if (dmem_we) begin
            wr_cnt++;
            last_wa = dmem_addr;
            last_wd = dmem_wdata;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        if (reset_n) cycle_check();
        @(posedge clock);
        #2;
    endtask

    task automatic start();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic reset_begin(input bit rnd);
        load_req  = 1'b1;
        reset_n   = 1'b0;
        run       = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        for (int i = 0; i < 8192; i++) imem[i] = 16'h0000;
        for (int i = 0; i < 65536; i++) init_mem[i] = rnd ? 8'($urandom) : 8'h00;
        q_dut.delete();
        m_outq.delete();
        wr_cnt  = 0;
        last_wa = 16'h0000;
        last_wd = 8'h00;
    endtask

    task automatic reset_end();
        @(posedge clock);
        @(posedge clock);
        #2;
        load_req = 1'b0;
        reset_n  = 1'b1;
    endtask

    task automatic wait_halt(input int budget, input string tag);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_halt_reached"}, halted, 1'b1);
        tick();
        tick();
    endtask

    task automatic wait_out_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_out_valid_seen"}, out_valid, 1'b1);
    endtask

    initial begin
        int          stall;
        logic [2:0]  op;
        logic [12:0] a;

        // Reset state and single output.
        reset_begin(1'b0);
        imem[0] = 16'h0005;
        imem[1] = 16'h8000;
        check("rst_imem_addr", imem_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_cycles", cycles, 0);
        reset_end();
        out_ready = 1'b1;
        tick();
        start();
        wait_halt(50, "t1");
        check("t1_out_count", q_dut.size(), 1);
        check("t1_out_byte", q_dut[0], 8'h05);
        check("t1_model_out_byte", m_outq[0], 8'h05);
`ifdef BF_CORE_CYCLE_COUNT_EN
        check("t1_cycles_frozen", cycles, 7);
        check("t1_model_cycles", m_cycles, 7);
`else
        check("t1_cycles_tied", cycles, 0);
`endif

        // dp wrap below zero and cell underflow.
        reset_begin(1'b0);
        imem[0] = 16'h6001;
        imem[1] = 16'h2001;
        imem[2] = 16'h8000;
        reset_end();
        out_ready = 1'b1;
        start();
        wait_halt(50, "t2");
        check("t2_write_addr", last_wa, 16'hFFFF);
        check("t2_write_data", last_wd, 8'hFF);
        check("t2_out_byte", q_dut[0], 8'hFF);

        // Counted loop.
        reset_begin(1'b0);
        imem[0] = 16'h0003;
        imem[1] = 16'hC003;
        imem[2] = 16'h2001;
        imem[3] = 16'hE001;
        imem[4] = 16'h8000;
        reset_end();
        out_ready = 1'b1;
        start();
        wait_halt(100, "t3");
        check("t3_model_dec_count", m_pc2_cnt, 3);
        check("t3_write_count", wr_cnt, 4);
        check("t3_out_count", q_dut.size(), 1);
        check("t3_out_byte", q_dut[0], 8'h00);

        // Output back-pressure.
        reset_begin(1'b0);
        imem[0] = 16'h0005;
        imem[1] = 16'h8000;
        reset_end();
        start();
        wait_out_valid("t4");
        stall = 0;
        repeat (10) begin
            tick();
            if (out_valid) stall++;
        end
        check("t4_stall_cycles", stall, 10);
        check("t4_no_early_transfer", q_dut.size(), 0);
        out_ready = 1'b1;
        wait_halt(50, "t4");
        check("t4_out_count", q_dut.size(), 1);
        check("t4_out_byte", q_dut[0], 8'h05);

        // Delayed input.
        reset_begin(1'b0);
        imem[0] = 16'hA000;
        imem[1] = 16'h8000;
        reset_end();
        out_ready = 1'b1;
        start();
        repeat (5) tick();
        check("t5_in_ready_waiting", in_ready, 1'b1);
        in_data  = 8'h41;
        in_valid = 1'b1;
        wait_halt(50, "t5");
        in_valid = 1'b0;
        check("t5_out_byte", q_dut[0], 8'h41);
        check("t5_ram_cell", dmem[0], 8'h41);

        // Asynchronous reset while holding an output; RAM keeps the earlier +5.
        reset_begin(1'b0);
        imem[0] = 16'h0005;
        imem[1] = 16'h8000;
        reset_end();
        start();
        wait_out_valid("t6");
        tick();
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_async_out_valid", out_valid, 0);
        check("t6_async_imem_addr", imem_addr, 0);
        check("t6_async_dmem_addr", dmem_addr, 0);
        check("t6_async_out_data", out_data, 0);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        q_dut.delete();
        m_outq.delete();
        repeat (3) tick();
        out_ready = 1'b1;
        start();
        wait_halt(50, "t6");
        check("t6_out_count", q_dut.size(), 1);
        check("t6_out_byte", q_dut[0], 8'h0A);

        // Randomized programs, memory contents and handshakes.
        for (int t = 0; t < 25; t++) begin
            int n;
            reset_begin(1'b1);
            for (int i = 0; i < 16; i++) begin
                op = 3'($urandom_range(0, 7));
                a  = (op >= 3'd6) ? 13'($urandom_range(0, 17)) : 13'($urandom);
                imem[i] = ($urandom_range(0, 15) == 0) ? 16'h0000 : {op, a};
            end
            reset_end();
            tick();
            start();
            n = 0;
            while (!halted && n < 300) begin
                out_ready = 1'($urandom_range(0, 1));
                in_valid  = 1'($urandom_range(0, 1));
                in_data   = 8'($urandom);
                tick();
                n++;
            end
            tick();
            check("rnd_out_count", q_dut.size(), m_outq.size());
            for (int k = 0; k < q_dut.size() && k < m_outq.size(); k++) begin
                check("rnd_out_byte", q_dut[k], m_outq[k]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
